// File: rtl/stream_packer_pkg.sv
// stream_packer_pkg: shared FSM type and sizing helpers for stream_word_packer.
// Build option: define STREAM_WORD_PACKER_BSWAP_EN for MSB-first lane order.
package stream_packer_pkg;

    typedef enum logic [0:0] {
        StFill = 1'b0,
        StSend = 1'b1
    } state_e;

    localparam int unsigned DEF_IN_WIDTH   = 8;
    localparam int unsigned DEF_OUT_WIDTH  = 32;
    localparam int unsigned DEF_FIFO_DEPTH = 16;
    localparam int unsigned DEF_SIZE_WIDTH = 12;

    // Samples per output word.
    function automatic int unsigned calc_ratio(input int unsigned in_width,
                                               input int unsigned out_width);
        return out_width / in_width;
    endfunction

    // Bytes contributed by one sample.
    function automatic int unsigned calc_bytes(input int unsigned in_width);
        return in_width / 8;
    endfunction

    // Lane counter width, never narrower than one bit.
    function automatic int unsigned calc_lane_cnt_w(input int unsigned ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    function automatic int unsigned calc_ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Bit offset of the lane that the lane-th sample of a word lands in.
    function automatic int unsigned lane_offset(input int unsigned lane,
                                                input int unsigned ratio,
                                                input int unsigned in_width);
`ifdef STREAM_WORD_PACKER_BSWAP_EN
        return (ratio - 1 - lane) * in_width;
`else
        return (lane % ratio) * in_width;
`endif
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: synchronous first-word-fall-through FIFO with occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo_fwft #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == DEPTH_CNT);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Storage array; contents are only meaningful where count says so.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/stream_word_packer.sv
// stream_word_packer: packs IN_WIDTH samples into OUT_WIDTH words, buffers one packet
// and forwards it with ready/last handshake and a byte count.
// Build option: STREAM_WORD_PACKER_BSWAP_EN places samples MSB-first within a word.
module stream_word_packer
    import stream_packer_pkg::*;
#(
    parameter int unsigned IN_WIDTH   = DEF_IN_WIDTH,
    parameter int unsigned OUT_WIDTH  = DEF_OUT_WIDTH,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned SIZE_WIDTH = DEF_SIZE_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [IN_WIDTH-1:0]   i_data,
    input  logic                  i_data_valid,
    input  logic                  i_data_last,
    output logic                  o_in_ready,
    input  logic                  i_tmanager_ready,
    output logic                  o_tanswer_ready,
    output logic [OUT_WIDTH-1:0]  o_tdata,
    output logic                  o_tanswer_data_last,
    output logic [SIZE_WIDTH-1:0] o_packet_size_in_bytes,
    output logic                  o_overflow
);

    localparam int unsigned RATIO       = calc_ratio(IN_WIDTH, OUT_WIDTH);
    localparam int unsigned BYTES       = calc_bytes(IN_WIDTH);
    localparam int unsigned LANE_CNT_W  = calc_lane_cnt_w(RATIO);
    localparam int unsigned PTR_W       = calc_ptr_w(FIFO_DEPTH);
    localparam int unsigned LANE_LAST_I = RATIO - 1;
    localparam int unsigned LAST_SLOT_I = FIFO_DEPTH - 1;

    localparam logic [LANE_CNT_W-1:0] LANE_LAST = LANE_LAST_I[LANE_CNT_W-1:0];
    localparam logic [PTR_W:0]        LAST_SLOT = LAST_SLOT_I[PTR_W:0];
    localparam logic [PTR_W:0]        ONE_ENTRY = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [SIZE_WIDTH-1:0] BYTES_SZ  = BYTES[SIZE_WIDTH-1:0];

    state_e                state_q;
    logic                  in_ready_q, overflow_q, discard_q;
    logic [SIZE_WIDTH-1:0] size_q, byte_cnt_q, byte_cnt_d;
    logic [LANE_CNT_W-1:0] lane_cnt_q, lane_cnt_d;
    logic [OUT_WIDTH-1:0]  word_q, word_d, merged;

    logic                  accept, keep, word_done, push, ovf_push, pkt_end, pop, send_valid;
    logic [OUT_WIDTH-1:0]  fifo_rdata;
    logic [PTR_W:0]        fifo_count;
    logic                  fifo_full, fifo_empty;

    // Acceptance, word assembly and packet-end detection.
    always_comb begin
        accept     = i_data_valid && in_ready_q;
        keep       = accept && !discard_q;
        merged     = word_q |
                     (OUT_WIDTH'(i_data) << lane_offset(32'(lane_cnt_q), RATIO, IN_WIDTH));
        word_done  = keep && (i_data_last || (lane_cnt_q == LANE_LAST));
        push       = word_done && !fifo_full;
        // Filling the last slot without a last sample forces the packet to end early.
        ovf_push   = push && !i_data_last && (fifo_count == LAST_SLOT);
        pkt_end    = keep && (i_data_last || ovf_push);
        send_valid = (state_q == StSend) && !fifo_empty;
        pop        = send_valid && i_tmanager_ready;

        byte_cnt_d = byte_cnt_q;
        lane_cnt_d = lane_cnt_q;
        word_d     = word_q;
        if (keep) begin
            byte_cnt_d = pkt_end ? '0 : byte_cnt_q + BYTES_SZ;
            if (word_done) begin
                lane_cnt_d = '0;
                word_d     = '0;
            end else begin
                lane_cnt_d = lane_cnt_q + 1'b1;
                word_d     = merged;
            end
        end
    end

    // Lane counter, partial word and running byte count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lane_cnt_q <= '0;
            word_q     <= '0;
            byte_cnt_q <= '0;
        end else begin
            lane_cnt_q <= lane_cnt_d;
            word_q     <= word_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    // Control FSM with registered ready, size and sticky overflow.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= StFill;
            in_ready_q <= 1'b0;
            size_q     <= '0;
            overflow_q <= 1'b0;
            discard_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StFill: begin
                    in_ready_q <= 1'b1;
                    // Dropping the tail of a truncated packet ends at its last sample.
                    if (accept && discard_q && i_data_last) begin
                        discard_q <= 1'b0;
                    end
                    if (pkt_end) begin
                        state_q    <= StSend;
                        in_ready_q <= 1'b0;
                        size_q     <= byte_cnt_q + BYTES_SZ;
                        if (ovf_push) begin
                            overflow_q <= 1'b1;
                            discard_q  <= 1'b1;
                        end
                    end
                end
                StSend: begin
                    if (pop && (fifo_count == ONE_ENTRY)) begin
                        state_q    <= StFill;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StFill;
                end
            endcase
        end
    end

    sync_fifo_fwft #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (i_clk),
        .rst_ni  (i_rst_n),
        .push_i  (push),
        .data_i  (merged),
        .pop_i   (pop),
        .data_o  (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign o_in_ready             = in_ready_q;
    assign o_tanswer_ready        = send_valid;
    assign o_tdata                = send_valid ? fifo_rdata : '0;
    assign o_tanswer_data_last    = send_valid && (fifo_count == ONE_ENTRY);
    assign o_packet_size_in_bytes = size_q;
    assign o_overflow             = overflow_q;

endmodule

// File: tb/tb_stream_word_packer.sv
// tb_stream_word_packer: randomized and directed bench for two packer configurations,
// instance 0 with defaults (8->32, depth 16) and instance 1 with 16->32, depth 4.
module tb_stream_word_packer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] s_data   [2];
    logic        s_valid  [2];
    logic        s_last   [2];
    logic        tm_ready [2];
    logic        in_ready [2];
    logic        tans_rdy [2];
    logic [31:0] tdata    [2];
    logic        tlast    [2];
    logic [11:0] psize    [2];
    logic        ovf      [2];

    stream_word_packer u_dut_a (
        .i_clk                  (clk),
        .i_rst_n                (rst_n),
        .i_data                 (s_data[0][7:0]),
        .i_data_valid           (s_valid[0]),
        .i_data_last            (s_last[0]),
        .o_in_ready             (in_ready[0]),
        .i_tmanager_ready       (tm_ready[0]),
        .o_tanswer_ready        (tans_rdy[0]),
        .o_tdata                (tdata[0]),
        .o_tanswer_data_last    (tlast[0]),
        .o_packet_size_in_bytes (psize[0]),
        .o_overflow             (ovf[0])
    );

    stream_word_packer #(
        .IN_WIDTH   (16),
        .OUT_WIDTH  (32),
        .FIFO_DEPTH (4),
        .SIZE_WIDTH (12)
    ) u_dut_b (
        .i_clk                  (clk),
        .i_rst_n                (rst_n),
        .i_data                 (s_data[1]),
        .i_data_valid           (s_valid[1]),
        .i_data_last            (s_last[1]),
        .o_in_ready             (in_ready[1]),
        .i_tmanager_ready       (tm_ready[1]),
        .o_tanswer_ready        (tans_rdy[1]),
        .o_tdata                (tdata[1]),
        .o_tanswer_data_last    (tlast[1]),
        .o_packet_size_in_bytes (psize[1]),
        .o_overflow             (ovf[1])
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Words popped by the answer port, in order, tagged with the instance.
    typedef struct packed {
        logic        sel;
        logic [31:0] word;
        logic        last;
        logic [11:0] size;
    } rx_t;

    rx_t         rx_q[$];
    int          tm_mode [2];
    int          pat_cnt [2];
    bit          hold_q  [2];
    logic [31:0] hold_d  [2];
    logic        hold_l  [2];
    bit          exp_ovf [2];

    // Answer-side monitor: drives manager ready, captures pops, checks hold/exclusion.
    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (!rst_n) begin
                hold_q[s]   = 1'b0;
                tm_ready[s] = 1'b0;
                pat_cnt[s]  = 0;
            end else begin
                if (hold_q[s]) begin
                    check("hold_valid", 64'(tans_rdy[s]), 64'd1);
                    check("hold_data", 64'(tdata[s]), 64'(hold_d[s]));
                    check("hold_last", 64'(tlast[s]), 64'(hold_l[s]));
                end
                if (tans_rdy[s]) check("in_ready_in_send", 64'(in_ready[s]), 64'd0);
                case (tm_mode[s])
                    0:       tm_ready[s] = 1'b1;
                    1:       tm_ready[s] = ($urandom_range(0, 2) != 0);
                    default: tm_ready[s] = ((pat_cnt[s] % 4) == 0) || ((pat_cnt[s] % 4) == 3);
                endcase
                if (tans_rdy[s]) pat_cnt[s]++;
                hold_q[s] = tans_rdy[s] && !tm_ready[s];
                hold_d[s] = tdata[s];
                hold_l[s] = tlast[s];
                if (tans_rdy[s] && tm_ready[s])
                    rx_q.push_back(rx_t'{sel: 1'(s), word: tdata[s], last: tlast[s],
                                         size: psize[s]});
            end
        end
    end

    // Reference: a packet is its samples grouped RATIO at a time, truncated to the FIFO.
    task automatic model_packet(input int s, input logic [15:0] smp[$],
                                output logic [31:0] ew[$], output int unsigned esz,
                                output bit eovf, output int fidx);
        int unsigned iw, dep, ratio, cap, n, used, nw, idx, lane;
        logic [31:0] w, v;
        iw    = (s == 0) ? 8 : 16;
        dep   = (s == 0) ? 16 : 4;
        ratio = 32 / iw;
        cap   = dep * ratio;
        n     = smp.size();
        eovf  = (n > cap);
        used  = eovf ? cap : n;
        fidx  = int'(used) - 1;
        nw    = (used + ratio - 1) / ratio;
        ew    = {};
        for (int unsigned k = 0; k < nw; k++) begin
            w = '0;
            for (int unsigned j = 0; j < ratio; j++) begin
                idx = k * ratio + j;
                if (idx < used) begin
                    v = 32'(smp[idx]) & ((32'd1 << iw) - 32'd1);
`ifdef STREAM_WORD_PACKER_BSWAP_EN
                    lane = ratio - 1 - j;
`else
                    lane = j;
`endif
                    w = w | (v << (lane * iw));
                end
            end
            ew.push_back(w);
        end
        esz = (used * (iw / 8)) % 4096;
    endtask

    // Drives samples from a negedge; returns at the negedge after the final acceptance.
    task automatic drive_packet(input int s, input logic [15:0] smp[$], input bit gaps,
                                input bit with_last, input int exp_idx);
        bit acc, done;
        int budget;
        for (int i = 0; i < smp.size(); i++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                // Stray last without valid must be ignored.
                s_valid[s] = 1'b0;
                s_last[s]  = 1'b1;
                s_data[s]  = 16'($urandom);
                @(negedge clk);
            end
            s_valid[s] = 1'b1;
            s_data[s]  = smp[i];
            s_last[s]  = with_last && (i == smp.size() - 1);
            done   = 1'b0;
            budget = 0;
            while (!done && budget < 400) begin
                acc = in_ready[s];
                @(negedge clk);
                done = acc;
                budget++;
            end
            if (!done) begin
                check("accept_timeout", 64'd0, 64'd1);
                break;
            end
            if (i == exp_idx) check("ready_latency", 64'(tans_rdy[s]), 64'd1);
            else if (i < exp_idx) check("ready_early", 64'(tans_rdy[s]), 64'd0);
        end
        s_valid[s] = 1'b0;
        s_last[s]  = 1'b0;
    endtask

    task automatic run_packet(input int s, input logic [15:0] smp[$], input bit gaps);
        logic [31:0] ew[$];
        logic [31:0] gw[$];
        bit          gl[$];
        int unsigned esz;
        bit          eovf;
        int          fidx, budget, nchk;
        bit          got_last;
        logic [11:0] gsz;
        rx_t         r;
        model_packet(s, smp, ew, esz, eovf, fidx);
        drive_packet(s, smp, gaps, 1'b1, fidx);
        got_last = 1'b0;
        gsz      = '0;
        budget   = 0;
        while (!got_last && budget < 3000) begin
            while (!got_last && rx_q.size() > 0) begin
                r = rx_q.pop_front();
                if (int'(r.sel) == s) begin
                    gw.push_back(r.word);
                    gl.push_back(r.last);
                    gsz      = r.size;
                    got_last = r.last;
                end
            end
            if (!got_last) begin
                @(negedge clk);
                budget++;
            end
        end
        if (!got_last) check("rx_timeout", 64'd0, 64'd1);
        check("nwords", 64'(gw.size()), 64'(ew.size()));
        nchk = (gw.size() < ew.size()) ? gw.size() : ew.size();
        for (int i = 0; i < nchk; i++) begin
            check("word", 64'(gw[i]), 64'(ew[i]));
            check("word_last", 64'(gl[i]), 64'(i == ew.size() - 1));
        end
        check("size", 64'(gsz), 64'(esz));
        repeat (2) @(negedge clk);
        check("size_hold", 64'(psize[s]), 64'(esz));
        exp_ovf[s] = exp_ovf[s] || eovf;
        check("overflow", 64'(ovf[s]), 64'(exp_ovf[s]));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] smp[$];
        int          s, cap, len;
        for (int k = 0; k < 2; k++) begin
            s_data[k]  = '0;
            s_valid[k] = 1'b0;
            s_last[k]  = 1'b0;
            tm_mode[k] = 0;
            exp_ovf[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_in_ready", 64'(in_ready[k]), 64'd0);
            check("rst_tans_ready", 64'(tans_rdy[k]), 64'd0);
            check("rst_tdata", 64'(tdata[k]), 64'd0);
            check("rst_tlast", 64'(tlast[k]), 64'd0);
            check("rst_size", 64'(psize[k]), 64'd0);
            check("rst_overflow", 64'(ovf[k]), 64'd0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 8-bit samples 0x01..0x08.
        smp = {};
        for (int i = 1; i <= 8; i++) smp.push_back(16'(i));
        run_packet(0, smp, 1'b0);
        // Partial final word.
        smp = '{16'hA1, 16'hA2, 16'hA3, 16'hA4, 16'hA5};
        run_packet(0, smp, 1'b0);
        // Backpressure 1-0-0-1.
        tm_mode[0] = 2;
        smp = {};
        for (int i = 0; i < 8; i++) smp.push_back(16'($urandom));
        run_packet(0, smp, 1'b0);
        tm_mode[0] = 0;
        // Minimum packet.
        smp = '{16'h5A};
        run_packet(0, smp, 1'b0);
        // 16-bit samples with partial word.
        smp = '{16'h1111, 16'h2222, 16'h3333};
        run_packet(1, smp, 1'b0);
        // Overflow truncation, then a normal packet.
        smp = {};
        for (int i = 0; i < 70; i++) smp.push_back(16'($urandom));
        run_packet(0, smp, 1'b0);
        smp = '{16'h11, 16'h22, 16'h33, 16'h44};
        run_packet(0, smp, 1'b0);
        smp = {};
        for (int i = 0; i < 10; i++) smp.push_back(16'($urandom));
        run_packet(1, smp, 1'b1);
        smp = '{16'hBEEF, 16'hCAFE, 16'h0123, 16'h4567};
        run_packet(1, smp, 1'b0);

        // Randomized packets, lengths occasionally beyond the FIFO.
        for (int p = 0; p < 24; p++) begin
            s   = int'($urandom_range(0, 1));
            cap = (s == 0) ? 64 : 8;
            len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(cap + 1, cap + 6))
                                              : int'($urandom_range(1, cap));
            tm_mode[s] = int'($urandom_range(0, 2));
            smp = {};
            for (int i = 0; i < len; i++) smp.push_back(16'($urandom));
            run_packet(s, smp, 1'($urandom_range(0, 1)));
        end
        tm_mode[0] = 0;
        tm_mode[1] = 0;

        // Asynchronous reset mid-packet.
        smp = '{16'h01, 16'h02, 16'h03};
        drive_packet(0, smp, 1'b0, 1'b0, -1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 64'(in_ready[0]), 64'd0);
        check("mid_rst_tans_ready", 64'(tans_rdy[0]), 64'd0);
        check("mid_rst_tdata", 64'(tdata[0]), 64'd0);
        check("mid_rst_tlast", 64'(tlast[0]), 64'd0);
        check("mid_rst_size", 64'(psize[0]), 64'd0);
        check("mid_rst_overflow", 64'(ovf[0]), 64'd0);
        exp_ovf[0] = 1'b0;
        exp_ovf[1] = 1'b0;
        rx_q = {};
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        smp = '{16'hD1, 16'hD2, 16'hD3, 16'hD4};
        run_packet(0, smp, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_word_packer.md
Name: stream_word_packer

Overview:
Parametrised, store-and-forward output packer between a processing core (DCT or similar) and the task manager answer port.
- Collects IN_WIDTH samples and packs them into OUT_WIDTH words.
- Buffers one packet in an internal FIFO and counts its size in bytes.
- Presents the packet with ready/last handshake and packet size once it is complete.
- Successor to the fixed 8-to-32 answer packer: generic widths and depth, backpressure, zero-padded partial words, and overflow truncation.

Parameters:
IN_WIDTH, 8, sample width in bits; multiple of 8; must divide OUT_WIDTH.
OUT_WIDTH, 32, answer word width in bits.
FIFO_DEPTH, 16, words buffered; power of two, ≥2.
SIZE_WIDTH, 12, width of packet byte count.

Ports:
i_clk  in  1  clock, rising edge.
i_rst_n  in  1  asynchronous, active-low reset.
i_data  in  IN_WIDTH  sample from core.
i_data_valid  in  1  sample valid.
i_data_last  in  1  final sample of packet; qualified by i_data_valid.
o_in_ready  out  1  packer accepts sample this cycle.
i_tmanager_ready  in  1  task manager accepts answer word.
o_tanswer_ready  out  1  o_tdata valid.
o_tdata  out  OUT_WIDTH  answer word, FIFO head.
o_tanswer_data_last  out  1  current word is last of packet.
o_packet_size_in_bytes  out  SIZE_WIDTH  byte count of packet being sent.
o_overflow  out  1  sticky: a packet was truncated.

Behaviour:
- Reset: all outputs 0, state FILL, lane counter 0, FIFO empty, discard flag 0.
- RATIO = OUT_WIDTH/IN_WIDTH; BYTES = IN_WIDTH/8.
- Sample accepted when i_data_valid && o_in_ready.

FSM states: FILL, SEND.

FILL:
- o_in_ready=1; o_tanswer_ready=0.
- Accepted sample goes into lane[lane_cnt], LSB-first: sample k occupies bits [(k+1)*IN_WIDTH-1 : k*IN_WIDTH].
- Byte counter += BYTES per accepted sample. Count wraps modulo 2^SIZE_WIDTH; no saturation.
- Word push: on acceptance with lane_cnt==RATIO-1, or with i_data_last.
  - A partial word on last has unfilled upper lanes zero.
  - lane_cnt returns to 0 and the shift register clears.
- On accepted last:
  - Latch byte count into o_packet_size_in_bytes; clear counter.
  - Go SEND. o_tanswer_ready rises the next cycle (latency 1 from last acceptance).
- Overflow: a push that makes FIFO count == FIFO_DEPTH without last →
  - Treat as forced end: latch size, set o_overflow, set discard flag, go SEND.
  - While the discard flag is set, the next FILL accepts and drops samples (no push, no count) up to and including the next last sample, then clears the flag and resumes normal FILL.

SEND:
- o_in_ready=0; o_tanswer_ready = FIFO non-empty.
- o_tdata = FIFO head (first-word-fall-through).
- o_tanswer_data_last = 1 when FIFO count==1.
- Pop on o_tanswer_ready && i_tmanager_ready.
- Pop of last word → FILL the following cycle. o_packet_size_in_bytes holds until the next latch.
- i_tmanager_ready low: o_tdata and o_tanswer_data_last hold stable.

Reset and sticky state:
- Reset mid-packet: FIFO, counters and partial word are discarded immediately (asynchronous).
- o_overflow clears only on reset.
- i_data_last without i_data_valid is ignored.
- Minimum packet is 1 sample.

Optional Feature:
STREAM_WORD_PACKER_BSWAP_EN
- Defined: lane order is MSB-first; sample k occupies the lane at index RATIO-1-k. Partial words are zero in the low lanes.
- Undefined: LSB-first as above.
- Byte counts and handshakes are identical in both builds.

Decomposition:
- Package stream_packer_pkg:
  - state enum (FILL, SEND);
  - localparam helpers RATIO, BYTES, LANE_CNT_W = $clog2(RATIO) (min 1), PTR_W = $clog2(FIFO_DEPTH);
  - function computing lane bit offset, honouring the BSWAP macro.
- Sub-module sync_fifo_fwft: parametrised width/depth, count output, full/empty. Instantiated once.

Test Plan:
1. Defaults, 8 samples 0x01..0x08, last on 0x08, manager always ready → words 0x04030201, 0x08070605; last on 2nd; size=8; o_tanswer_ready one cycle after last accepted.
2. 5 samples 0xA1..0xA5 → words 0x A4A3A2A1, 0x000000A5; size=5. With BSWAP_EN: 0xA1A2A3A4, 0xA5000000.
3. Backpressure: 8-sample packet, i_tmanager_ready toggles 1-0-0-1 → o_tdata stable while low; o_in_ready=0 throughout SEND; no sample accepted during SEND.
4. FIFO_DEPTH=4, 20 samples, last on 20th → after 16 samples o_overflow=1, 4 words sent, size=16; samples 17–20 dropped; next 4-sample packet sent normally, size=4.
5. IN_WIDTH=16, OUT_WIDTH=32, samples 0x1111, 0x2222, 0x3333 (last) → 0x22221111, 0x00003333; size=6.
6. Reset asserted after 3 samples of a packet → all outputs 0 immediately; after release, new 4-sample packet yields a single correct word, size=4.
